bf_core: RTL and testbench
==========================

BF_CORE -- requirements
Module: bf_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register, bus-data and immediate width; legal values 8..32.
REQ-002 SHALL have parameter ADDR_W, default 8: pc and memory-address width; legal when ADDR_W <= DATA_W.
REQ-003 SHALL have parameter RESET_PC, default 0: pc value loaded at reset.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk and rst (active-low).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 mem_ready  input  1  memory accepts or completes the current request in this cycle.
REQ-008 mem_rdata  input  DATA_W  read data, valid when mem_req, !mem_we and mem_ready are all high.
REQ-009 mem_req  output  1  bus request.
REQ-010 mem_we  output  1  write strobe, qualified by mem_req.
REQ-011 mem_addr  output  ADDR_W  bus address.
REQ-012 mem_wdata  output  DATA_W  write data.
REQ-013 halted  output  1  core has stopped on HALT.
REQ-014 retire  output  1  one-cycle pulse when an instruction completes.

Function
REQ-015 Each instruction SHALL be two bus words fetched from pc, then pc+1.
- Word0 fields: [7:4] op, [3:0] r0.
- Word1 fields: [7:4] r1 and [3:0] r2 for ADD/NAND; otherwise full-width imm, with addr = word1[ADDR_W-1:0].
REQ-016 The register file SHALL be 16 x DATA_W, all zero after reset.
REQ-017 Opcodes SHALL be:
- JMP=0: pc=addr.
- LOD=1: r0=M[addr].
- STR=2: M[addr]=r0.
- ADD=3: r0=r1+r2.
- ADDI=4: r0=r0+imm.
- LODI=5: r0=imm.
- NAND=6: r0=~(r1&r2).
- JEQZ=7: pc=addr if r0==0.
- HALT=8.
- Opcodes 9..15: NOP.
REQ-018 Arithmetic SHALL be modulo 2^DATA_W, with no flags. pc SHALL wrap modulo 2^ADDR_W; pc=2^ADDR_W-1 fetches word1 from address 0.
REQ-019 The FSM SHALL have states FETCH0, FETCH1, EXEC, MEM, HALT.
- After reset: FETCH0.
- FETCH0 -> FETCH1 -> EXEC.
- EXEC -> MEM for LOD/STR.
- EXEC -> HALT for HALT.
- EXEC -> FETCH0 otherwise.
- MEM -> FETCH0.
REQ-020 Bus handshake:
- In FETCH0, FETCH1 and MEM, mem_req SHALL be high, with mem_addr, mem_we and mem_wdata held stable until the edge where mem_req && mem_ready.
- That edge completes the transfer and advances the state.
- mem_req SHALL be low in EXEC and HALT.
REQ-021 Latency with mem_ready tied high:
- Register and jump instructions: 3 cycles.
- LOD/STR: 4 cycles.
- Each wait cycle adds exactly one cycle.
REQ-022 pc SHALL advance by 2 in EXEC unless a taken jump loads addr.
REQ-023 Register writes SHALL occur at the EXEC edge (ADD, ADDI, LODI, NAND) or at the MEM completion edge (LOD).
REQ-024 retire SHALL pulse high for one cycle on the edge after each instruction completes, including NOP, not-taken JEQZ and HALT.
REQ-025 HALT state SHALL be terminal until reset: halted=1, mem_req=0, no register or pc change.
REQ-026 An operand register that is written by the same instruction SHALL be read before the write (e.g. ADD r3,r3,r3 doubles r3).

Reset
REQ-027 On rst low, asynchronously:
- state=FETCH0, pc=RESET_PC, registers=0.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, retire=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no register or pc update. After release, the first mem_req SHALL rise on the first edge after deassertion, at address RESET_PC.

Structure
REQ-029 Package bf_pkg SHALL hold the opcode constants (OP_JMP..OP_HALT) and the state encoding.
REQ-030 One sub-module, bf_alu, SHALL implement ADD, ADDI, NAND and LODI combinationally, parameterised by DATA_W.

Verification
REQ-031 Reset release with RESET_PC=0x10 and mem_ready=1 -> mem_req=1 at addr 0x10, then 0x11, then retire pulse.
REQ-032 LODI r1,0x05; ADDI r1,0xFF -> r1=0x04 (wrap); ADD r2,r1,r1 -> r2=0x08; NAND r3,r2,r2 -> r3=0xF7.
REQ-033 STR r2,0x80 then LOD r4,0x80 with mem_ready low for 3 cycles per access -> write of 0x08 at 0x80, r4=0x08, each access 3 cycles longer.
REQ-034 JEQZ r0,0x40 with r0=0 -> next fetch at 0x40. With r0=1 -> next fetch at pc+2.
REQ-035 HALT -> halted=1, retire once, mem_req stays 0 for 20 cycles. Then rst pulse -> fetch restarts at RESET_PC.
REQ-036 DATA_W=16, ADDR_W=8: LODI r5,0xFFFF; ADDI r5,0x0002 -> r5=0x0001. Jump to 0xFF -> fetch words at 0xFF, then 0x00.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared opcode constants and FSM state encoding for the bf_core two-word
// instruction processor.
package bf_pkg;

  localparam logic [3:0] OP_JMP  = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LODI = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_JEQZ = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

endpackage

// File: rtl/bf_alu.sv
// Combinational result path for the register-writing opcodes; wr_en flags
// which opcodes commit a result to r0.
module bf_alu
  import bf_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              wr_en
);

  always_comb begin
    result = '0;
    wr_en  = 1'b0;
    case (op)
      OP_ADD:  begin result = rs1_val + rs2_val;    wr_en = 1'b1; end
      OP_ADDI: begin result = rd_val + imm;         wr_en = 1'b1; end
      OP_NAND: begin result = ~(rs1_val & rs2_val); wr_en = 1'b1; end
      OP_LODI: begin result = imm;                  wr_en = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/bf_core.sv
// Multi-cycle core: fetches two bus words per instruction, executes, and
// optionally performs one data access. All bus outputs are registered.
module bf_core
  import bf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halted,
  output logic              retire
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [7:0]        ir0_q, ir0_d;
  logic [DATA_W-1:0] ir1_q, ir1_d, mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, retire_q, retire_d;
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];

  logic [3:0]        op, ra, rb, rc;
  logic [ADDR_W-1:0] jaddr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_we, xfer;

  assign op    = ir0_q[7:4];
  assign ra    = ir0_q[3:0];
  assign rb    = ir1_q[7:4];
  assign rc    = ir1_q[3:0];
  assign jaddr = ir1_q[ADDR_W-1:0];
  assign xfer  = mem_req_q && mem_ready;

  bf_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op),
    .rd_val  (regs_q[ra]),
    .rs1_val (regs_q[rb]),
    .rs2_val (regs_q[rc]),
    .imm     (ir1_q),
    .result  (alu_res),
    .wr_en   (alu_we)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir0_d       = ir0_q;
    ir1_d       = ir1_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retire_d    = 1'b0;
    regs_d      = regs_q;
    case (state_q)
      S_FETCH0: begin
        // Only true in the first cycle after reset: raise the first request.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ready) begin
          ir0_d      = mem_rdata[7:0];
          mem_addr_d = pc_q + ADDR_W'(1);
          state_d    = S_FETCH1;
        end
      end
      S_FETCH1: begin
        if (xfer) begin
          ir1_d     = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        retire_d  = 1'b1;
        pc_d      = pc_q + ADDR_W'(2);
        state_d   = S_FETCH0;
        mem_req_d = 1'b1;
        mem_we_d  = 1'b0;
        if (alu_we) regs_d[ra] = alu_res;
        case (op)
          OP_JMP:  pc_d = jaddr;
          OP_JEQZ: if (regs_q[ra] == '0) pc_d = jaddr;
          OP_LOD, OP_STR: begin
            retire_d    = 1'b0;
            state_d     = S_MEM;
            mem_addr_d  = jaddr;
            mem_we_d    = (op == OP_STR);
            mem_wdata_d = regs_q[ra];
          end
          OP_HALT: begin
            state_d   = S_HALT;
            mem_req_d = 1'b0;
          end
          default: ;
        endcase
        if (state_d == S_FETCH0) mem_addr_d = pc_d;
      end
      S_MEM: begin
        if (xfer) begin
          if (!mem_we_q) regs_d[ra] = mem_rdata;
          retire_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
          state_d    = S_FETCH0;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH0;
      pc_q        <= RESET_PC_V;
      ir0_q       <= '0;
      ir1_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir0_q       <= ir0_d;
      ir1_q       <= ir1_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      regs_q      <= regs_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign retire    = retire_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_bf_core.sv
// Directed bench for bf_core: an 8-bit core at RESET_PC=0x10 with data-access
// wait states, and a 16-bit core exercising wide immediates and pc wrap.
module tb_bf_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 8-bit core and its memory
  logic       rst8, ready8, req8, we8, halted8, retire8, hold8, wait_en;
  logic [7:0] rdata8, addr8, wdata8;
  logic [7:0] mem8 [256];
  logic [2:0] wcnt = '0;

  bf_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(16)) u_core8 (
    .clk(clk), .rst(rst8), .mem_ready(ready8), .mem_rdata(rdata8),
    .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
    .halted(halted8), .retire(retire8)
  );

  assign rdata8 = mem8[addr8];
  // Data accesses to 0x80 see three not-ready cycles before completing.
  assign ready8 = !hold8 && !(wait_en && req8 && addr8 == 8'h80 && wcnt < 3'd3);

  always @(posedge clk) begin
    if (req8 && addr8 == 8'h80) begin
      if (wcnt < 3'd3) wcnt <= wcnt + 3'd1;
    end else begin
      wcnt <= '0;
    end
  end

  // 16-bit core and its memory
  logic        rst16, req16, we16, halted16, retire16;
  logic        ready16 = 1'b1;
  logic [7:0]  addr16;
  logic [15:0] rdata16, wdata16;
  logic [15:0] mem16 [256];

  bf_core #(.DATA_W(16), .ADDR_W(8), .RESET_PC(0)) u_core16 (
    .clk(clk), .rst(rst16), .mem_ready(ready16), .mem_rdata(rdata16),
    .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
    .halted(halted16), .retire(retire16)
  );

  assign rdata16 = mem16[addr16];

  // Transfer records: {we, addr, wdata-or-zero}
  logic [31:0] tr8[$];
  logic [31:0] tr16[$];
  int          ret8[$];
  int          cyc = 0;

  function automatic logic [31:0] rd(input logic [7:0] a);
    return {15'd0, 1'b0, a, 8'd0};
  endfunction
  function automatic logic [31:0] wr(input logic [7:0] a, input logic [7:0] d);
    return {15'd0, 1'b1, a, d};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem8[i]  = 8'h00;
      mem16[i] = 16'h0000;
    end
    mem8[8'h10] = 8'h51; mem8[8'h11] = 8'h05;  // LODI r1,0x05
    mem8[8'h12] = 8'h41; mem8[8'h13] = 8'hFF;  // ADDI r1,0xFF
    mem8[8'h14] = 8'h32; mem8[8'h15] = 8'h11;  // ADD  r2,r1,r1
    mem8[8'h16] = 8'h63; mem8[8'h17] = 8'h22;  // NAND r3,r2,r2
    mem8[8'h18] = 8'h22; mem8[8'h19] = 8'h80;  // STR  r2,0x80
    mem8[8'h1A] = 8'h14; mem8[8'h1B] = 8'h80;  // LOD  r4,0x80
    mem8[8'h1C] = 8'h70; mem8[8'h1D] = 8'h40;  // JEQZ r0,0x40
    mem8[8'h1E] = 8'h80;                       // HALT (skipped)
    mem8[8'h40] = 8'h21; mem8[8'h41] = 8'h81;  // STR  r1,0x81
    mem8[8'h42] = 8'h23; mem8[8'h43] = 8'h84;  // STR  r3,0x84
    mem8[8'h44] = 8'h24; mem8[8'h45] = 8'h83;  // STR  r4,0x83
    mem8[8'h46] = 8'h33; mem8[8'h47] = 8'h33;  // ADD  r3,r3,r3
    mem8[8'h48] = 8'h23; mem8[8'h49] = 8'h82;  // STR  r3,0x82
    mem8[8'h4A] = 8'h50; mem8[8'h4B] = 8'h01;  // LODI r0,0x01
    mem8[8'h4C] = 8'h70; mem8[8'h4D] = 8'h60;  // JEQZ r0,0x60
    mem8[8'h4E] = 8'h90; mem8[8'h4F] = 8'h00;  // NOP
    mem8[8'h50] = 8'h80; mem8[8'h51] = 8'h00;  // HALT
    mem8[8'h60] = 8'h80;                       // HALT (skipped)
    mem16[8'h00] = 16'h0055; mem16[8'h01] = 16'hFFFF;  // LODI r5,0xFFFF
    mem16[8'h02] = 16'h0045; mem16[8'h03] = 16'h0002;  // ADDI r5,0x0002
    mem16[8'h04] = 16'h0025; mem16[8'h05] = 16'h0090;  // STR  r5,0x90
    mem16[8'h06] = 16'h0000; mem16[8'h07] = 16'hAAFF;  // JMP  0xFF
    mem16[8'hFF] = 16'h0080;                           // HALT
    forever begin
      @(negedge clk);
      cyc++;
      if (rst8 && req8 && ready8) begin
        tr8.push_back(we8 ? wr(addr8, wdata8) : rd(addr8));
        if (we8) mem8[addr8] = wdata8;
      end
      if (retire8) ret8.push_back(cyc);
      if (rst16 && req16 && ready16) begin
        tr16.push_back({we16, addr16, (we16 ? wdata16 : 16'h0000)});
        if (we16) mem16[addr16] = wdata16;
      end
    end
  end

  logic [31:0] exp8 [38];
  logic [31:0] exp16 [11];
  int          exp_gap [15];
  int          n, reqs;

  initial begin
    exp8 = '{rd(8'h10), rd(8'h11), rd(8'h12), rd(8'h13), rd(8'h14), rd(8'h15),
             rd(8'h16), rd(8'h17), rd(8'h18), rd(8'h19), wr(8'h80, 8'h08),
             rd(8'h1A), rd(8'h1B), rd(8'h80), rd(8'h1C), rd(8'h1D),
             rd(8'h40), rd(8'h41), wr(8'h81, 8'h04), rd(8'h42), rd(8'h43),
             wr(8'h84, 8'hF7), rd(8'h44), rd(8'h45), wr(8'h83, 8'h08),
             rd(8'h46), rd(8'h47), rd(8'h48), rd(8'h49), wr(8'h82, 8'hEE),
             rd(8'h4A), rd(8'h4B), rd(8'h4C), rd(8'h4D), rd(8'h4E), rd(8'h4F),
             rd(8'h50), rd(8'h51)};
    exp16 = '{{7'd0, 1'b0, 8'h00, 16'h0}, {7'd0, 1'b0, 8'h01, 16'h0},
              {7'd0, 1'b0, 8'h02, 16'h0}, {7'd0, 1'b0, 8'h03, 16'h0},
              {7'd0, 1'b0, 8'h04, 16'h0}, {7'd0, 1'b0, 8'h05, 16'h0},
              {7'd0, 1'b1, 8'h90, 16'h0001},
              {7'd0, 1'b0, 8'h06, 16'h0}, {7'd0, 1'b0, 8'h07, 16'h0},
              {7'd0, 1'b0, 8'hFF, 16'h0}, {7'd0, 1'b0, 8'h00, 16'h0}};
    exp_gap = '{3, 3, 3, 7, 7, 3, 4, 4, 4, 3, 4, 3, 3, 3, 3};

    rst8 = 1'b0; rst16 = 1'b0; hold8 = 1'b0; wait_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",    {31'd0, req8},    32'd0);
    check("rst_we",     {31'd0, we8},     32'd0);
    check("rst_addr",   {24'd0, addr8},   32'd0);
    check("rst_wdata",  {24'd0, wdata8},  32'd0);
    check("rst_halted", {31'd0, halted8}, 32'd0);
    check("rst_retire", {31'd0, retire8}, 32'd0);
    check("rst_req16",  {31'd0, req16},   32'd0);

    @(negedge clk); rst8 = 1'b1; rst16 = 1'b1;
    @(posedge clk); #1;
    check("boot_req0",  {31'd0, req8},    32'd1);
    check("boot_addr0", {24'd0, addr8},   32'h10);
    @(posedge clk); #1;
    check("boot_req1",  {31'd0, req8},    32'd1);
    check("boot_addr1", {24'd0, addr8},   32'h11);
    @(posedge clk); #1;
    check("exec_req",   {31'd0, req8},    32'd0);
    check("exec_ret",   {31'd0, retire8}, 32'd0);
    @(posedge clk); #1;
    check("retire_hi",  {31'd0, retire8}, 32'd1);
    @(posedge clk); #1;
    check("retire_lo",  {31'd0, retire8}, 32'd0);

    n = 0;
    while (!(halted8 && halted16) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("halted8",  {31'd0, halted8},  32'd1);
    check("halted16", {31'd0, halted16}, 32'd1);

    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (req8) reqs++;
    end
    check("halt_no_req",  reqs,              32'd0);
    check("halt_stays",   {31'd0, halted8},  32'd1);
    check("retire_count", ret8.size(),       32'd16);
    for (int i = 1; i < ret8.size() && i < 16; i++)
      check($sformatf("latency%0d", i), ret8[i] - ret8[i-1], exp_gap[i-1]);

    check("trace8_len", tr8.size(), 32'd38);
    for (int i = 0; i < tr8.size() && i < 38; i++)
      check($sformatf("trace8[%0d]", i), tr8[i], exp8[i]);
    check("trace16_len", tr16.size(), 32'd11);
    for (int i = 0; i < tr16.size() && i < 11; i++)
      check($sformatf("trace16[%0d]", i), tr16[i], exp16[i]);

    // Restart from HALT, then abort a stalled fetch with an async reset.
    hold8 = 1'b1;
    @(negedge clk); rst8 = 1'b0;
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    check("restart_req",    {31'd0, req8},    32'd1);
    check("restart_addr",   {24'd0, addr8},   32'h10);
    check("restart_halted", {31'd0, halted8}, 32'd0);
    @(posedge clk); #1;
    check("stall_req",  {31'd0, req8},  32'd1);
    check("stall_addr", {24'd0, addr8}, 32'h10);
    #2 rst8 = 1'b0;
    #1;
    check("async_req",  {31'd0, req8},  32'd0);
    check("async_addr", {24'd0, addr8}, 32'd0);
    hold8 = 1'b0;
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    check("rerun_req",   {31'd0, req8},  32'd1);
    check("rerun_addr0", {24'd0, addr8}, 32'h10);
    @(posedge clk); #1;
    check("rerun_addr1", {24'd0, addr8}, 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
